// File: rtl/mcr_load_pkg.sv
// Shared constants, state type and decode helper for the MCR1 load controller.
package mcr_load_pkg;

    // ioctl download indices handled by the controller
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // game-select byte values
    localparam logic [7:0] MOD_KICK     = 8'd0;
    localparam logic [7:0] MOD_SOLARFOX = 8'd1;

    // core reset sequencer states
    typedef enum logic [1:0] {
        UNLOADED = 2'd0,
        LOADING  = 2'd1,
        HOLD     = 2'd2,
        RUN      = 2'd3
    } load_state_t;

    // A byte strobe only counts while a download is active and targets the wanted index.
    function automatic logic strobe_hit(input logic       download,
                                        input logic       wr,
                                        input logic [7:0] index,
                                        input logic [7:0] want);
        return download & wr & (index == want);
    endfunction

endpackage

// File: rtl/mcr_load_ctrl_if.sv
// HPS ioctl download stream as seen by the load controller.
interface mcr_load_ctrl_if;

    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    // HPS side drives the stream
    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout
    );

    // controller side consumes the stream
    modport slave (
        input ioctl_download,
        input ioctl_index,
        input ioctl_wr,
        input ioctl_addr,
        input ioctl_dout
    );

endinterface

// File: rtl/mcr_reset_seq.sv
// Core reset sequencer: keeps the MCR1 core in reset until a ROM image has
// been loaded, then releases it after a fixed hold period. Any later download
// or user reset puts the core back into reset.
module mcr_reset_seq
    import mcr_load_pkg::*;
#(
    parameter int HOLD_CYCLES = 65535
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic rom_downloading,
    input  logic user_reset,
    output logic core_reset
);

    // HOLD_CYCLES=0 would give a zero-width counter, so keep at least one bit.
    localparam int              CNT_W     = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    load_state_t      state_r;
    load_state_t      state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             core_reset_r;
    logic             core_reset_next_s;

    // State, hold counter and registered core reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r      <= UNLOADED;
            cnt_r        <= HOLD_LOAD;
            core_reset_r <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            core_reset_r <= core_reset_next_s;
        end
    end

    // Next-state selection; a download always wins over a user reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            UNLOADED: begin
                if (rom_downloading) state_next_s = LOADING;
                else                 state_next_s = UNLOADED;
            end
            LOADING: begin
                if (!rom_downloading) state_next_s = HOLD;
                else                  state_next_s = LOADING;
            end
            HOLD: begin
                if (rom_downloading)       state_next_s = LOADING;
                else if (user_reset)       state_next_s = HOLD;
                else if (cnt_r == CNT_ZERO) state_next_s = RUN;
                else                       state_next_s = HOLD;
            end
            RUN: begin
                if (rom_downloading) state_next_s = LOADING;
                else if (user_reset) state_next_s = HOLD;
                else                 state_next_s = RUN;
            end
            default: state_next_s = UNLOADED;
        endcase
    end

    // Counter update and core reset level for the coming cycle.
    always_comb begin
        cnt_next_s        = cnt_r;
        core_reset_next_s = 1'b1;
        if ((state_next_s == HOLD) && ((state_r != HOLD) || user_reset)) begin
            cnt_next_s = HOLD_LOAD;
        end else if ((state_r == HOLD) && (cnt_r != CNT_ZERO)) begin
            cnt_next_s = cnt_r - CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
        if (state_next_s == RUN) core_reset_next_s = 1'b0;
        else                     core_reset_next_s = 1'b1;
    end

    assign core_reset = core_reset_r;

endmodule

// File: rtl/mcr_load_ctrl.sv
// MCR1 load controller: decodes the HPS ioctl download stream into ROM
// writes, the game-select byte and DIP bytes, and drives the core reset.
module mcr_load_ctrl
    import mcr_load_pkg::*;
#(
    parameter int         ROM_AW      = 16,
    parameter int         HOLD_CYCLES = 65535,
    parameter int         DIP_BYTES   = 8,
    parameter logic [7:0] DIP_DEFAULT = 8'hFF
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   user_reset,
    mcr_load_ctrl_if.slave         ioctl,
    output logic                   rom_we,
    output logic [ROM_AW-1:0]      rom_waddr,
    output logic [7:0]             rom_wdata,
    output logic                   rom_downloading,
    output logic                   rom_loaded,
    output logic [7:0]             mod_sel,
    output logic                   mod_kick,
    output logic                   mod_solarfox,
    output logic [8*DIP_BYTES-1:0] dip,
    output logic                   core_reset
);

    logic              rom_hit_s;
    logic              mod_hit_s;
    logic              dip_hit_s;
    logic              rom_dl_now_s;
    logic              rom_in_range_s;

    logic              rom_we_r;
    logic [ROM_AW-1:0] rom_waddr_r;
    logic [7:0]        rom_wdata_r;
    logic              rom_dl_r;
    logic              rom_dl_prev_r;
    logic              rom_loaded_r;
    logic [7:0]        mod_sel_r;
    logic              mod_kick_r;
    logic              mod_solarfox_r;
    logic [7:0]        dip_r [DIP_BYTES];

    // Address bits above the ROM window must all be zero for a ROM write.
    assign rom_in_range_s = ((ioctl.ioctl_addr >> ROM_AW) == 25'd0);
    assign rom_hit_s      = strobe_hit(ioctl.ioctl_download, ioctl.ioctl_wr, ioctl.ioctl_index, IDX_ROM)
                            & rom_in_range_s;
    assign mod_hit_s      = strobe_hit(ioctl.ioctl_download, ioctl.ioctl_wr, ioctl.ioctl_index, IDX_MOD);
    assign dip_hit_s      = strobe_hit(ioctl.ioctl_download, ioctl.ioctl_wr, ioctl.ioctl_index, IDX_DIP);
    assign rom_dl_now_s   = ioctl.ioctl_download & (ioctl.ioctl_index == IDX_ROM);

    // ROM write port: one-cycle registered copy of each accepted index-0 byte.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_we_r    <= 1'b0;
            rom_waddr_r <= {ROM_AW{1'b0}};
            rom_wdata_r <= 8'd0;
        end else begin
            rom_we_r <= rom_hit_s;
            if (rom_hit_s) begin
                rom_waddr_r <= ioctl.ioctl_addr[ROM_AW-1:0];
                rom_wdata_r <= ioctl.ioctl_dout;
            end else begin
                rom_waddr_r <= rom_waddr_r;
                rom_wdata_r <= rom_wdata_r;
            end
        end
    end

    // Download flag and its delayed copy; deliberately not cleared by reset so
    // a download in flight across a block reset is still tracked to its end.
    always_ff @(posedge clk_sys) begin
        rom_dl_r      <= rom_dl_now_s;
        rom_dl_prev_r <= rom_dl_r;
    end

    // Sticky "ROM loaded" flag, set one cycle after rom_downloading falls.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_loaded_r <= 1'b0;
        end else if (rom_dl_prev_r & ~rom_dl_r) begin
            rom_loaded_r <= 1'b1;
        end else begin
            rom_loaded_r <= rom_loaded_r;
        end
    end

    // Game-select byte with its decoded flags; the last write wins.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mod_sel_r      <= MOD_KICK;
            mod_kick_r     <= 1'b1;
            mod_solarfox_r <= 1'b0;
        end else if (mod_hit_s) begin
            mod_sel_r      <= ioctl.ioctl_dout;
            mod_kick_r     <= (ioctl.ioctl_dout == MOD_KICK);
            mod_solarfox_r <= (ioctl.ioctl_dout == MOD_SOLARFOX);
        end else begin
            mod_sel_r      <= mod_sel_r;
            mod_kick_r     <= mod_kick_r;
            mod_solarfox_r <= mod_solarfox_r;
        end
    end

    for (genvar n = 0; n < DIP_BYTES; n++) begin : g_dip
        // One capture register per DIP byte; addresses beyond the last byte never match.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                dip_r[n] <= DIP_DEFAULT;
            end else if (dip_hit_s && (ioctl.ioctl_addr == 25'(n))) begin
                dip_r[n] <= ioctl.ioctl_dout;
            end else begin
                dip_r[n] <= dip_r[n];
            end
        end
        assign dip[8*n +: 8] = dip_r[n];
    end

    mcr_reset_seq #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_reset_seq (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .rom_downloading (rom_dl_r),
        .user_reset      (user_reset),
        .core_reset      (core_reset)
    );

    assign rom_we          = rom_we_r;
    assign rom_waddr       = rom_waddr_r;
    assign rom_wdata       = rom_wdata_r;
    assign rom_downloading = rom_dl_r;
    assign rom_loaded      = rom_loaded_r;
    assign mod_sel         = mod_sel_r;
    assign mod_kick        = mod_kick_r;
    assign mod_solarfox    = mod_solarfox_r;

endmodule

// File: tb/tb_mcr_load_ctrl.sv
// Bench for mcr_load_ctrl: directed phases plus a randomized phase, every
// cycle compared against a behavioural model of the load/reset rules.
module tb_mcr_load_ctrl;

    localparam int ROM_AW = 16;
    localparam int HOLD   = 16;
    localparam int NDIP   = 8;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic              reset;
    logic              user_reset;
    logic              rom_we;
    logic [ROM_AW-1:0] rom_waddr;
    logic [7:0]        rom_wdata;
    logic              rom_downloading;
    logic              rom_loaded;
    logic [7:0]        mod_sel;
    logic              mod_kick;
    logic              mod_solarfox;
    logic [8*NDIP-1:0] dip;
    logic              core_reset;

    mcr_load_ctrl_if bus ();

    mcr_load_ctrl #(
        .ROM_AW      (ROM_AW),
        .HOLD_CYCLES (HOLD),
        .DIP_BYTES   (NDIP),
        .DIP_DEFAULT (8'hFF)
    ) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .user_reset      (user_reset),
        .ioctl           (bus),
        .rom_we          (rom_we),
        .rom_waddr       (rom_waddr),
        .rom_wdata       (rom_wdata),
        .rom_downloading (rom_downloading),
        .rom_loaded      (rom_loaded),
        .mod_sel         (mod_sel),
        .mod_kick        (mod_kick),
        .mod_solarfox    (mod_solarfox),
        .dip             (dip),
        .core_reset      (core_reset)
    );

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model state
    bit          m_we      = 1'b0;
    logic [15:0] m_waddr   = 16'd0;
    logic [7:0]  m_wdata   = 8'd0;
    bit          m_dl      = 1'b0;
    bit          m_dl_prev = 1'b0;
    bit          m_loaded  = 1'b0;
    logic [7:0]  m_mod     = 8'd0;
    logic [7:0]  m_dip [NDIP];
    bit          m_core    = 1'b1;
    bit          m_waiting = 1'b1;   // no ROM download seen since reset
    bit          m_loading = 1'b0;   // ROM download in progress
    int          m_left    = HOLD;   // remaining hold cycles, -1 when released

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the rules to the inputs seen at the clock edge that just passed.
    task automatic model_update();
        bit old_dl;
        bit old_prev;
        bit strobe;
        old_dl    = m_dl;
        old_prev  = m_dl_prev;
        m_dl_prev = old_dl;
        m_dl      = bus.ioctl_download && (bus.ioctl_index == 8'd0);
        strobe    = bus.ioctl_download && bus.ioctl_wr;
        if (reset) begin
            m_we      = 1'b0;
            m_loaded  = 1'b0;
            m_mod     = 8'd0;
            for (int i = 0; i < NDIP; i++) m_dip[i] = 8'hFF;
            m_waiting = 1'b1;
            m_loading = 1'b0;
            m_left    = HOLD;
        end else begin
            m_we = strobe && (bus.ioctl_index == 8'd0) && (bus.ioctl_addr < (25'd1 << ROM_AW));
            if (m_we) begin
                m_waddr = bus.ioctl_addr[15:0];
                m_wdata = bus.ioctl_dout;
            end
            if (old_prev && !old_dl) m_loaded = 1'b1;
            if (strobe && (bus.ioctl_index == 8'd1)) m_mod = bus.ioctl_dout;
            if (strobe && (bus.ioctl_index == 8'd254) && (bus.ioctl_addr < 25'(NDIP)))
                m_dip[int'(bus.ioctl_addr)] = bus.ioctl_dout;
            if (old_dl) begin
                m_loading = 1'b1;
                m_waiting = 1'b0;
            end else if (m_loading) begin
                m_loading = 1'b0;
                m_left    = HOLD;
            end else if (m_waiting) begin
                m_left = m_left;
            end else if (user_reset) begin
                m_left = HOLD;
            end else if (m_left >= 0) begin
                m_left = m_left - 1;
            end
        end
        m_core = m_waiting || m_loading || (m_left >= 0);
    endtask

    task automatic check_all();
        logic [63:0] exp_dip;
        exp_dip = 64'd0;
        for (int i = 0; i < NDIP; i++) exp_dip[8*i +: 8] = m_dip[i];
        chk("rom_we", 64'(rom_we), 64'(m_we));
        if (m_we) begin
            chk("rom_waddr", 64'(rom_waddr), 64'(m_waddr));
            chk("rom_wdata", 64'(rom_wdata), 64'(m_wdata));
        end
        chk("rom_downloading", 64'(rom_downloading), 64'(m_dl));
        chk("rom_loaded", 64'(rom_loaded), 64'(m_loaded));
        chk("mod_sel", 64'(mod_sel), 64'(m_mod));
        chk("mod_kick", 64'(mod_kick), 64'(m_mod == 8'd0));
        chk("mod_solarfox", 64'(mod_solarfox), 64'(m_mod == 8'd1));
        chk("dip", 64'(dip), exp_dip);
        chk("core_reset", 64'(core_reset), 64'(m_core));
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
        model_update();
        check_all();
    endtask

    task automatic drive(input logic dl, input logic [7:0] idx, input logic wr,
                         input logic [24:0] a, input logic [7:0] d);
        bus.ioctl_download = dl;
        bus.ioctl_index    = idx;
        bus.ioctl_wr       = wr;
        bus.ioctl_addr     = a;
        bus.ioctl_dout     = d;
    endtask

    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        drive(1'b1, idx, 1'b1, a, d);
        step();
    endtask

    task automatic dl_begin(input logic [7:0] idx);
        drive(1'b1, idx, 1'b0, 25'd0, 8'd0);
        step();
    endtask

    task automatic dl_end();
        drive(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
        step();
    endtask

    initial begin
        logic       dl_on;
        logic [7:0] cur_idx;
        dl_on   = 1'b0;
        cur_idx = 8'd0;
        for (int i = 0; i < NDIP; i++) m_dip[i] = 8'hFF;

        // reset state
        reset      = 1'b1;
        user_reset = 1'b0;
        drive(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();

        // index-0 download of A0..A3 at 0..3, then hold and release
        dl_begin(8'd0);
        for (int i = 0; i < 4; i++) wr_byte(8'd0, 25'(i), 8'(8'hA0 + i));
        dl_end();
        repeat (HOLD + 6) step();

        // ROM window boundaries and random ROM bytes
        dl_begin(8'd0);
        wr_byte(8'd0, 25'h10000, 8'($urandom));
        wr_byte(8'd0, 25'h0FFFF, 8'h5A);
        for (int i = 0; i < 6; i++)
            wr_byte(8'd0, ($urandom_range(0, 1) == 1) ? 25'($urandom_range(0, 65535)) : 25'($urandom),
                    8'($urandom));
        dl_end();
        repeat (HOLD + 4) step();

        // game-select byte, then a strobe with no download active
        dl_begin(8'd1);
        wr_byte(8'd1, 25'($urandom), 8'h00);
        wr_byte(8'd1, 25'($urandom), 8'h01);
        dl_end();
        drive(1'b0, 8'd1, 1'b1, 25'd0, 8'h00);
        step();
        dl_begin(8'd1);
        for (int i = 0; i < 3; i++) wr_byte(8'd1, 25'($urandom), 8'($urandom_range(0, 2)));
        dl_end();

        // DIP bytes 0..8; byte 8 is outside the DIP array
        dl_begin(8'd254);
        for (int i = 0; i < 9; i++) wr_byte(8'd254, 25'(i), 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) wr_byte(8'd254, 25'($urandom_range(0, 11)), 8'($urandom));
        dl_end();

        // user reset for 3 cycles while running
        user_reset = 1'b1;
        repeat (3) step();
        user_reset = 1'b0;
        repeat (HOLD + 4) step();

        // user reset arriving together with a ROM download
        dl_begin(8'd0);
        user_reset = 1'b1;
        step();
        user_reset = 1'b0;
        repeat (3) step();
        dl_end();
        repeat (HOLD + 4) step();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                dl_on = ~dl_on;
                case ($urandom_range(0, 3))
                    0:       cur_idx = 8'd0;
                    1:       cur_idx = 8'd1;
                    2:       cur_idx = 8'd254;
                    default: cur_idx = 8'd3;
                endcase
            end
            drive(dl_on, cur_idx, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? 25'($urandom_range(0, 9)) : 25'($urandom),
                  8'($urandom));
            user_reset = ($urandom_range(0, 29) == 0);
            reset      = ($urandom_range(0, 149) == 0);
            step();
        end
        reset      = 1'b0;
        user_reset = 1'b0;
        dl_end();
        repeat (HOLD + 4) step();

        // block reset in the middle of a ROM download
        dl_begin(8'd0);
        wr_byte(8'd0, 25'd0, 8'($urandom));
        wr_byte(8'd0, 25'd1, 8'($urandom));
        reset = 1'b1;
        drive(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
        step();
        reset = 1'b0;
        wr_byte(8'd0, 25'd2, 8'($urandom));
        wr_byte(8'd0, 25'd3, 8'($urandom));
        dl_end();
        repeat (HOLD + 5) step();

        // final reset restores DIP defaults
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
